// File: rtl/matmul_pkg.sv
// Shared types and constants for the sequential matrix multiplier.
// Element (r,c) of a flat matrix bus lives at bits [idx(r,c) +: DW].
package matmul_pkg;

  localparam int unsigned MAX_N  = 5;
  localparam int unsigned DW     = 8;
  localparam int unsigned FLAT_W = MAX_N * MAX_N * DW;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } state_e;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return (r * MAX_N + c) * DW;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational signed DW x DW multiplier: wrapped DW-bit product plus overflow flag.
module multiplier
  import matmul_pkg::*;
(
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] prod,
  output logic          ovf
);

  logic signed [2*DW-1:0] full;

  always_comb begin
    full = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    prod = full[DW-1:0];
    ovf  = (full[2*DW-1:DW-1] != {(DW+1){full[DW-1]}});
    if (rst) begin
      prod = '0;
      ovf  = 1'b0;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer computing C = A x B one MAC per clock through a single shared multiplier.
// Results wrap to DW bits; ovf is sticky over the whole operation.
module matmul_seq
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  size,
  input  logic [FLAT_W-1:0] a_flat,
  input  logic [FLAT_W-1:0] b_flat,
  output logic [FLAT_W-1:0] c_flat,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              size_err
);

  state_e              state_q, state_d;
  logic [FLAT_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [IDX_W-1:0]    n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, serr_q, serr_d;

  logic [DW-1:0]       op_a, op_b, prod, sum;
  logic                mul_ovf, add_ovf, size_ok, last_k, last_j, last_i;

  multiplier u_mul (
    .rst  (1'b0),
    .a    (op_a),
    .b    (op_b),
    .prod (prod),
    .ovf  (mul_ovf)
  );

  // Operand muxing and wrapping accumulate
  always_comb begin
    op_a    = a_q[idx(32'(i_q), 32'(k_q)) +: DW];
    op_b    = b_q[idx(32'(k_q), 32'(j_q)) +: DW];
    sum     = acc_q + prod;
    add_ovf = (acc_q[DW-1] == prod[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
    size_ok = (size >= IDX_W'(2)) && (32'(size) <= MAX_N);
    last_k  = (k_q == n_q - IDX_W'(1));
    last_j  = (j_q == n_q - IDX_W'(1));
    last_i  = (i_q == n_q - IDX_W'(1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    serr_d  = serr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            // size is captured with its legality check so MAC never sees an unchecked N
            n_d     = size;
            busy_d  = 1'b1;
            state_d = LOAD;
          end else begin
            serr_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        a_d     = a_flat;
        b_d     = b_flat;
        c_d     = '0;
        ovf_d   = 1'b0;
        serr_d  = 1'b0;
        acc_d   = '0;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = sum;
        ovf_d = ovf_q | mul_ovf | add_ovf;
        k_d   = k_q + IDX_W'(1);
        if (last_k) state_d = WRITE;
      end
      WRITE: begin
        c_d[idx(32'(i_q), 32'(j_q)) +: DW] = acc_q;
        acc_d = '0;
        k_d   = '0;
        if (last_j) begin
          j_d = '0;
          i_d = i_q + IDX_W'(1);
        end else begin
          j_d = j_q + IDX_W'(1);
        end
        if (last_i && last_j) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = MAC;
        end
      end
      DONE: begin
        // A rejected start reaches DONE straight from IDLE, so its pulse is issued here
        done_d  = serr_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
    end
  end

  assign c_flat   = c_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign size_err = serr_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: vector table with a reference model and scoreboard,
// plus hand sequences for ignored starts and resets.
module tb_matmul_seq;
  import matmul_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        size;
  logic [FLAT_W-1:0] a_flat, b_flat, c_flat;
  logic              busy, done, ovf, size_err;

  matmul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .size     (size),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .c_flat   (c_flat),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .size_err (size_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        size;
    logic [FLAT_W-1:0] a;
    logic [FLAT_W-1:0] b;
    logic              exp_serr;
    int                exp_edge;
    logic              has_c;
    logic [FLAT_W-1:0] c_const;
    logic              exp_ovf_const;
  } vec_t;

  typedef struct {
    logic [FLAT_W-1:0] c;
    logic              ovf;
    logic              serr;
    int                edge_n;
    int                busy_n;
  } exp_t;

  int                n_checks = 0;
  int                n_errors = 0;
  exp_t              sb[$];
  vec_t              vecs[$];
  logic [FLAT_W-1:0] m_c;
  logic              m_ovf, m_serr;

  task automatic chk_v(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int el(input logic [FLAT_W-1:0] f, input int r, input int c);
    byte t;
    t = f[(r * MAX_N + c) * DW +: DW];
    return int'(t);
  endfunction

  function automatic logic [FLAT_W-1:0] put(input logic [FLAT_W-1:0] f, input int r, input int c, input int v);
    logic [FLAT_W-1:0] g;
    g = f;
    g[(r * MAX_N + c) * DW +: DW] = 8'(v);
    return g;
  endfunction

  function automatic logic [FLAT_W-1:0] m2(input int v00, input int v01, input int v10, input int v11);
    logic [FLAT_W-1:0] f;
    f = '0;
    f = put(f, 0, 0, v00);
    f = put(f, 0, 1, v01);
    f = put(f, 1, 0, v10);
    f = put(f, 1, 1, v11);
    return f;
  endfunction

  function automatic logic [FLAT_W-1:0] rnd_flat();
    logic [FLAT_W-1:0] f;
    for (int n = 0; n < MAX_N * MAX_N; n++) f[n * DW +: DW] = 8'($urandom);
    return f;
  endfunction

  function automatic int wrap8(input int v);
    byte t;
    t = byte'(v);
    return int'(t);
  endfunction

  function automatic vec_t mk(input int sz, input logic [FLAT_W-1:0] a, input logic [FLAT_W-1:0] b,
                              input logic serr, input int edge_n, input logic has_c,
                              input logic [FLAT_W-1:0] c, input logic ovf_c);
    vec_t v;
    v.size = 3'(sz);
    v.a = a;
    v.b = b;
    v.exp_serr = serr;
    v.exp_edge = edge_n;
    v.has_c = has_c;
    v.c_const = c;
    v.exp_ovf_const = ovf_c;
    return v;
  endfunction

  // Reference: exact integer arithmetic, then wrap to 8 bits
  task automatic model_push(input vec_t v);
    exp_t e;
    int   n, acc, full, p, s;
    n = int'(v.size);
    e.edge_n = v.exp_edge;
    e.serr   = v.exp_serr;
    if (!v.exp_serr) begin
      e.c = '0;
      e.ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < n; j++) begin
          acc = 0;
          for (int k = 0; k < n; k++) begin
            full = el(v.a, i, k) * el(v.b, k, j);
            if (full > 127 || full < -128) e.ovf = 1'b1;
            p = wrap8(full);
            s = acc + p;
            if (s > 127 || s < -128) e.ovf = 1'b1;
            acc = wrap8(s);
          end
          e.c = put(e.c, i, j, acc);
        end
      end
      e.busy_n = v.exp_edge;
    end else begin
      e.c = m_c;
      e.ovf = m_ovf;
      e.busy_n = 0;
    end
    m_c = e.c;
    m_ovf = e.ovf;
    m_serr = e.serr;
    sb.push_back(e);
  endtask

  task automatic run_op(input vec_t v, input bit poke);
    exp_t e;
    int   busy_cnt, got_edge, extra;
    bit   seen;
    @(negedge clk);
    size = v.size;
    a_flat = v.a;
    b_flat = v.b;
    start = 1'b1;
    model_push(v);
    busy_cnt = 0;
    got_edge = -1;
    seen = 1'b0;
    for (int ed = 0; ed < 300 && !seen; ed++) begin
      @(posedge clk);
      #1;
      if (ed == 0) start = 1'b0;
      if (ed == 2) begin
        a_flat = rnd_flat();
        b_flat = rnd_flat();
      end
      if (poke && ed == 4) begin
        start = 1'b1;
        size = 3'd3;
      end
      if (poke && ed == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        got_edge = ed;
      end
    end
    e = sb.pop_front();
    chk_i("done_edge", got_edge, e.edge_n);
    chk_i("busy_cycles", busy_cnt, e.busy_n);
    chk_v("c_flat", c_flat, e.c);
    chk_i("ovf", int'(ovf), int'(e.ovf));
    chk_i("size_err", int'(size_err), int'(e.serr));
    if (v.has_c) begin
      chk_v("c_const", c_flat, v.c_const);
      chk_i("ovf_const", int'(ovf), int'(v.exp_ovf_const));
    end
    if (poke) begin
      start = 1'b1;
      size = 3'd2;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_i("done_pulse", int'(done), 0);
    if (poke) begin
      extra = 0;
      for (int t = 0; t < 20; t++) begin
        @(posedge clk);
        #1;
        if (busy || done) extra++;
      end
      chk_i("ignored_start", extra, 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [FLAT_W-1:0] id3, b3, tmp;
    vec_t v;

    rst = 1'b0;
    start = 1'b0;
    size = '0;
    a_flat = '0;
    b_flat = '0;
    m_c = '0;
    m_ovf = 1'b0;
    m_serr = 1'b0;

    id3 = '0;
    for (int i = 0; i < 3; i++) id3 = put(id3, i, i, 1);
    b3 = '0;
    b3 = put(b3, 0, 0, -1);  b3 = put(b3, 0, 1, 2);  b3 = put(b3, 0, 2, -3);
    b3 = put(b3, 1, 0, 4);   b3 = put(b3, 1, 1, -5); b3 = put(b3, 1, 2, 6);
    b3 = put(b3, 2, 0, -7);  b3 = put(b3, 2, 1, 8);  b3 = put(b3, 2, 2, -128);

    vecs.push_back(mk(2, m2(1, 2, 3, 4), m2(5, 6, 7, 8), 1'b0, 13, 1'b1, m2(19, 22, 43, 50), 1'b0));
    vecs.push_back(mk(3, id3, b3, 1'b0, 37, 1'b1, b3, 1'b0));
    vecs.push_back(mk(2, m2(100, 100, 100, 100), m2(100, 100, 100, 100), 1'b0, 13, 1'b1, m2(32, 32, 32, 32), 1'b1));
    vecs.push_back(mk(2, m2(100, 100, 0, 0), m2(1, 0, 1, 0), 1'b0, 13, 1'b1, m2(8'hC8, 0, 0, 0), 1'b1));
    vecs.push_back(mk(2, m2(1, 1, 1, 1), m2(2, 3, 4, 5), 1'b0, 13, 1'b1, m2(6, 8, 6, 8), 1'b0));
    vecs.push_back(mk(4, rnd_flat(), rnd_flat(), 1'b0, 81, 1'b0, '0, 1'b0));
    vecs.push_back(mk(5, rnd_flat(), rnd_flat(), 1'b0, 151, 1'b0, '0, 1'b0));
    vecs.push_back(mk(6, rnd_flat(), rnd_flat(), 1'b1, 1, 1'b0, '0, 1'b0));
    vecs.push_back(mk(1, rnd_flat(), rnd_flat(), 1'b1, 1, 1'b0, '0, 1'b0));
    vecs.push_back(mk(0, rnd_flat(), rnd_flat(), 1'b1, 1, 1'b0, '0, 1'b0));
    vecs.push_back(mk(7, rnd_flat(), rnd_flat(), 1'b1, 1, 1'b0, '0, 1'b0));
    vecs.push_back(mk(2, rnd_flat(), rnd_flat(), 1'b0, 13, 1'b0, '0, 1'b0));

    repeat (3) @(negedge clk);
    chk_v("rst_c_flat", c_flat, '0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_ovf", int'(ovf), 0);
    chk_i("rst_size_err", int'(size_err), 0);
    rst = 1'b1;

    foreach (vecs[n]) run_op(vecs[n], 1'b0);

    // Second start mid-operation and during DONE must be dropped
    run_op(vecs[0], 1'b1);

    // Reset while idle clears the results of a rejected start
    run_op(vecs[7], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_i("idle_rst_size_err", int'(size_err), 0);
    chk_v("idle_rst_c_flat", c_flat, '0);
    @(negedge clk);
    rst = 1'b1;
    m_c = '0;
    m_ovf = 1'b0;
    m_serr = 1'b0;

    // Reset in the middle of a 3x3 operation
    tmp = rnd_flat();
    @(negedge clk);
    size = 3'd3;
    a_flat = tmp;
    b_flat = rnd_flat();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_i("midop_rst_busy", int'(busy), 0);
    chk_i("midop_rst_done", int'(done), 0);
    chk_i("midop_rst_ovf", int'(ovf), 0);
    chk_v("midop_rst_c_flat", c_flat, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_c = '0;
    m_ovf = 1'b0;
    m_serr = 1'b0;
    v = mk(3, tmp, rnd_flat(), 1'b0, 37, 1'b0, '0, 1'b0);
    run_op(v, 1'b0);

    chk_i("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
